// File: rtl/obstacle_gen_pkg.sv
// Shared lane-hazard definitions, also used by the score/collision block.
package obstacle_gen_pkg;

  localparam int LANES       = 3;
  localparam int FAST_HZ_AMT = 500;

  // Taps at bits 15, 13, 12, 10 (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SAFE_SEED = 16'h0001;

  typedef logic [LANES-1:0] lane_row_t;

  typedef enum logic [LANES-1:0] {
    LANE_NONE  = 3'b000,
    LANE_RIGHT = 3'b001,
    LANE_MID   = 3'b010,
    LANE_LEFT  = 3'b100
  } lane_e;

  localparam lane_row_t ROW_FULL = 3'b111;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_gen_if.sv
// Lane-hazard interface between the obstacle generator and the score/collision block.
interface obstacle_gen_if;
  import obstacle_gen_pkg::*;

  logic      game_over;
  lane_row_t obstacle1;
  lane_row_t obstacle2;
  lane_row_t obstacle3;
  lane_row_t obstacle4;
  logic      row_tick;

  modport master (
    input  game_over,
    output obstacle1, obstacle2, obstacle3, obstacle4, row_tick
  );

  modport slave (
    output game_over,
    input  obstacle1, obstacle2, obstacle3, obstacle4, row_tick
  );

endinterface

// File: rtl/obstacle_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when asked; a zero seed is replaced so it never locks up.
module lfsr16
  import obstacle_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] q
);

  logic [15:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (advance) q_d = lfsr_step(q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= (seed == 16'h0000) ? LFSR_SAFE_SEED : seed;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_gen.sv
// Generates gapped pseudo-random 3-lane obstacle rows and scrolls them toward the player,
// shortening the row period over time; everything freezes while game_over is high.
module obstacle_gen
  import obstacle_gen_pkg::*;
#(
  parameter int          START_TICKS_PER_ROW = 250,
  parameter int          END_TICKS_PER_ROW   = 50,
  parameter int          TICKS_TO_SPEEDUP    = 750,
  parameter int          GAP_ROWS            = 1,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic          fast_hz,
  input  logic          rst,
  obstacle_gen_if.master bus
);

  localparam int CW = 16;
  localparam int GW = 8;
  localparam logic [CW-1:0] START_TPR  = CW'(START_TICKS_PER_ROW);
  localparam logic [CW-1:0] END_TPR    = CW'(END_TICKS_PER_ROW);
  localparam logic [CW-1:0] SPEED_LAST = CW'(TICKS_TO_SPEEDUP - 1);
  localparam logic [GW-1:0] GAP_LIM    = GW'(GAP_ROWS);

  logic [CW-1:0] counter_d, counter_q;
  logic [CW-1:0] speed_d, speed_q;
  logic [CW-1:0] tpr_d, tpr_q;
  logic [GW-1:0] gap_d, gap_q;
  lane_row_t     o1_d, o1_q, o2_d, o2_q, o3_d, o3_q, o4_d, o4_q;
  logic          row_tick_d, row_tick_q;

  logic          running;
  logic          shift;
  lane_row_t     new_row;
  logic [15:0]   lfsr_val;
  logic          unused_lfsr;

  assign running = !bus.game_over;
  // >= rather than == so a period shortened mid-row cannot skip past the terminal count
  assign shift   = running && (counter_q >= tpr_q - 1'b1);

  lfsr16 u_lfsr (
    .clk     (fast_hz),
    .rst     (rst),
    .seed    (LFSR_SEED),
    .advance (shift),
    .q       (lfsr_val)
  );

  assign unused_lfsr = ^lfsr_val[15:3];

  always_comb begin
    new_row = LANE_NONE;
    gap_d   = gap_q;
    if (shift) begin
      if (gap_q < GAP_LIM) begin
        new_row = LANE_NONE;
        gap_d   = gap_q + 1'b1;
      end else begin
        new_row = (lfsr_val[2:0] == ROW_FULL) ? LANE_MID : lfsr_val[2:0];
        // an empty pick leaves the gap satisfied, so the next row may be non-empty
        if (new_row != LANE_NONE) gap_d = '0;
      end
    end
  end

  always_comb begin
    counter_d  = counter_q;
    speed_d    = speed_q;
    tpr_d      = tpr_q;
    row_tick_d = 1'b0;
    o1_d       = o1_q;
    o2_d       = o2_q;
    o3_d       = o3_q;
    o4_d       = o4_q;
    if (running) begin
      if (speed_q == SPEED_LAST) begin
        speed_d = '0;
        if (tpr_q > END_TPR) tpr_d = tpr_q - 1'b1;
      end else begin
        speed_d = speed_q + 1'b1;
      end
      if (shift) begin
        counter_d  = '0;
        row_tick_d = 1'b1;
        o4_d       = o3_q;
        o3_d       = o2_q;
        o2_d       = o1_q;
        o1_d       = new_row;
      end else begin
        counter_d = counter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge fast_hz) begin
    if (!rst) begin
      counter_q  <= '0;
      speed_q    <= '0;
      tpr_q      <= START_TPR;
      gap_q      <= '0;
      o1_q       <= '0;
      o2_q       <= '0;
      o3_q       <= '0;
      o4_q       <= '0;
      row_tick_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      speed_q    <= speed_d;
      tpr_q      <= tpr_d;
      gap_q      <= gap_d;
      o1_q       <= o1_d;
      o2_q       <= o2_d;
      o3_q       <= o3_d;
      o4_q       <= o4_d;
      row_tick_q <= row_tick_d;
    end
  end

  assign bus.obstacle1 = o1_q;
  assign bus.obstacle2 = o2_q;
  assign bus.obstacle3 = o3_q;
  assign bus.obstacle4 = o4_q;
  assign bus.row_tick  = row_tick_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Self-checking bench for obstacle_gen: row-tick timing table plus a row scoreboard fed by an LFSR model.
module tb_obstacle_gen;
  import obstacle_gen_pkg::*;

  localparam int TB_GAP = 1;

  logic fast_hz;
  logic rst_a, rst_b, rst_c;

  initial fast_hz = 1'b0;
  always #5 fast_hz = ~fast_hz;

  obstacle_gen_if if_a ();
  obstacle_gen_if if_b ();
  obstacle_gen_if if_c ();

  obstacle_gen dut_a (
    .fast_hz (fast_hz),
    .rst     (rst_a),
    .bus     (if_a)
  );

  obstacle_gen #(
    .START_TICKS_PER_ROW (8),
    .END_TICKS_PER_ROW   (3),
    .TICKS_TO_SPEEDUP    (20)
  ) dut_b (
    .fast_hz (fast_hz),
    .rst     (rst_b),
    .bus     (if_b)
  );

  obstacle_gen #(
    .START_TICKS_PER_ROW (6),
    .END_TICKS_PER_ROW   (2),
    .TICKS_TO_SPEEDUP    (10),
    .LFSR_SEED           (16'h0000)
  ) dut_c (
    .fast_hz (fast_hz),
    .rst     (rst_c),
    .bus     (if_c)
  );

  int          sel;
  logic        mon_tick;
  logic [11:0] mon_rows;

  always_comb begin
    mon_tick = 1'b0;
    mon_rows = '0;
    case (sel)
      0: begin
        mon_tick = if_a.row_tick;
        mon_rows = {if_a.obstacle1, if_a.obstacle2, if_a.obstacle3, if_a.obstacle4};
      end
      1: begin
        mon_tick = if_b.row_tick;
        mon_rows = {if_b.obstacle1, if_b.obstacle2, if_b.obstacle3, if_b.obstacle4};
      end
      default: begin
        mon_tick = if_c.row_tick;
        mon_rows = {if_c.obstacle1, if_c.obstacle2, if_c.obstacle3, if_c.obstacle4};
      end
    endcase
  end

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: row generator and expected-row queue
  logic [15:0] m_lfsr;
  int          m_gap;
  logic [2:0]  exp_q[$];

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset(input logic [15:0] seed);
    m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
    m_gap  = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int n);
    logic [2:0] r;
    for (int i = 0; i < n; i++) begin
      if (m_gap < TB_GAP) begin
        r = 3'b000;
        m_gap++;
      end else begin
        r = m_lfsr[2:0];
        if (r == 3'b111) r = 3'b010;
        if (r != 3'b000) m_gap = 0;
      end
      m_lfsr = ref_next(m_lfsr);
      exp_q.push_back(r);
    end
  endtask

  logic        sb_en;
  logic [11:0] sh;
  int          empties;
  int          since_tick;
  int          last_interval;

  task automatic sb_reset();
    sh         = '0;
    empties    = 0;
    since_tick = 0;
  endtask

  task automatic step();
    logic [2:0] e;
    @(posedge fast_hz);
    #1;
    since_tick++;
    if (mon_tick) begin
      last_interval = since_tick;
      since_tick    = 0;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=extra_row_tick required=no_tick at %0t", $time);
        end else begin
          e  = exp_q.pop_front();
          sh = {e, sh[11:3]};
          chk("rows", {20'h0, mon_rows}, {20'h0, sh});
          chk("no_full_row", {31'h0, mon_rows[11:9] == 3'b111}, 32'h0);
          if (mon_rows[11:9] != 3'b000) begin
            chk("gap_invariant", {31'h0, empties >= TB_GAP}, 32'h1);
            empties = 0;
          end else begin
            empties++;
          end
        end
      end
    end
  endtask

  task automatic wait_tick(input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!mon_tick && n < bound);
    chk("tick_seen", {31'h0, mon_tick}, 32'h1);
  endtask

  typedef struct {
    int freeze_cycles;
    int exp_interval;
  } vec_t;

  vec_t        vecs[10];
  logic [11:0] snap;
  bit          seen[8];
  int          ndistinct;

  initial begin
    vecs[0] = '{0, 250};
    vecs[1] = '{0, 250};
    vecs[2] = '{7, 257};
    vecs[3] = '{0, 249};
    vecs[4] = '{3, 252};
    vecs[5] = '{0, 249};
    vecs[6] = '{0, 248};
    vecs[7] = '{0, 248};
    vecs[8] = '{20, 268};
    vecs[9] = '{0, 247};

    checks = 0;
    failures = 0;
    sel = 0;
    sb_en = 1'b0;
    last_interval = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    if_a.game_over = 1'b0;
    if_b.game_over = 1'b0;
    if_c.game_over = 1'b0;
    sb_reset();

    repeat (3) step();
    chk("rst_rows_a", {20'h0, mon_rows}, 32'h0);
    chk("rst_tick_a", {31'h0, mon_tick}, 32'h0);
    sel = 1;
    #1;
    chk("rst_rows_b", {20'h0, mon_rows}, 32'h0);

    // Default-rate instance: tick timing, speedup and freeze-extended intervals
    sel = 0;
    #1;
    model_reset(16'hACE1);
    model_push(20);
    sb_reset();
    sb_en = 1'b1;
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].freeze_cycles > 0) begin
        if_a.game_over = 1'b1;
        repeat (vecs[i].freeze_cycles) step();
        if_a.game_over = 1'b0;
      end
      wait_tick(vecs[i].exp_interval + 5);
      chk($sformatf("interval[%0d]", i), last_interval, vecs[i].exp_interval);
      if (i == 0) chk("first_rows_empty", {20'h0, mon_rows}, 32'h0);
    end
    step();
    chk("tick_single_cycle", {31'h0, mon_tick}, 32'h0);

    // Fast instance: 2000 rows against the model, period floor
    sel = 1;
    #1;
    model_reset(16'hACE1);
    model_push(2000);
    sb_reset();
    rst_b = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      wait_tick(20);
      if (i >= 100) chk("floor_interval", last_interval, 3);
    end
    chk("sb_drain_2000", exp_q.size(), 0);

    // game_over raised in the cycle the counter sits at its terminal count
    model_push(60);
    step();
    chk("pre_freeze_tick1", {31'h0, mon_tick}, 32'h0);
    step();
    chk("pre_freeze_tick2", {31'h0, mon_tick}, 32'h0);
    if_b.game_over = 1'b1;
    snap = mon_rows;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("freeze_tick", {31'h0, mon_tick}, 32'h0);
      chk("freeze_hold", {20'h0, mon_rows}, {20'h0, snap});
    end
    if_b.game_over = 1'b0;
    step();
    chk("release_tick", {31'h0, mon_tick}, 32'h1);

    // Mid-run reset reproduces the power-on sequence and timing
    repeat (5) wait_tick(20);
    sb_en = 1'b0;
    rst_b = 1'b0;
    step();
    chk("midrst_rows", {20'h0, mon_rows}, 32'h0);
    chk("midrst_tick", {31'h0, mon_tick}, 32'h0);
    model_reset(16'hACE1);
    model_push(300);
    sb_reset();
    sb_en = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_tick(20);
      if (i == 0) chk("midrst_first_interval", last_interval, 8);
    end
    chk("sb_drain_rerun", exp_q.size(), 0);

    // Zero seed is replaced by 1 and still yields varied rows
    sel = 2;
    #1;
    chk("seed0_lfsr", {16'h0, dut_c.lfsr_val}, 32'h0001);
    model_reset(16'h0000);
    model_push(100);
    sb_reset();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    rst_c = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wait_tick(20);
      seen[mon_rows[11:9]] = 1'b1;
    end
    ndistinct = 0;
    for (int i = 1; i < 8; i++) if (seen[i]) ndistinct++;
    chk("seed0_nonconst", {31'h0, ndistinct >= 2}, 32'h1);
    chk("sb_drain_seed0", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
